sram_controller: RTL and testbench

Multi-cycle data-memory controller for the MEM stage of the 5-stage ARM pipeline. It replaces the single-cycle data memory. It takes the MEM-stage read/write request (ALU result as address, Rm value as store data), runs each 32-bit access as two 16-bit external SRAM transactions, and holds `ready` low so the rest of the pipeline freezes until the word completes.

---
 rtl/arm_pkg.sv | 13 +
 rtl/sram_controller.sv | 116 +++++++++++
 tb/tb_sram_controller.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Definitions shared between the data-memory controller and the CPU top level.
package arm_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PH_LO = 2'd1,
    S_PH_HI = 2'd2,
    S_DONE  = 2'd3
  } mem_state_t;

  localparam int unsigned DATA_MEM_BASE = 1024;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage data memory: each 32-bit access runs as two 16-bit SRAM phases.
// ready stays low until the word completes, which freezes the pipeline.
module sram_controller
  import arm_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned BASE_ADDR   = DATA_MEM_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam int unsigned CW     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE_W = 32'(BASE_ADDR);

  mem_state_t    state, next_state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          req;
  logic          op_wr;
  logic [16:0]   word_idx;
  logic [15:0]   wdata_hi;
  logic [18:0]   off;
  logic          unused_bits;

  // Only offset bits [18:2] select a word; higher bits alias.
  assign off         = address[18:0] - BASE_W[18:0];
  assign unused_bits = ^{address[31:19], off[1:0]};
  assign req         = wr_en | rd_en;
  assign last        = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = ~req;
        if (req) next_state = S_PH_LO;
      end
      S_PH_LO: if (last) next_state = S_PH_HI;
      S_PH_HI: if (last) next_state = S_DONE;
      S_DONE: begin
        ready      = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      op_wr       <= 1'b0;
      word_idx    <= '0;
      wdata_hi    <= '0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          // Write wins when both enables are set; the low phase is set up here.
          op_wr      <= wr_en;
          word_idx   <= off[18:2];
          wdata_hi   <= write_data[31:16];
          cnt        <= '0;
          sram_addr  <= {off[18:2], 1'b0};
          sram_we_n  <= ~wr_en;
          sram_dq_oe <= wr_en;
          if (wr_en) sram_dq_out <= write_data[15:0];
        end
        S_PH_LO: begin
          if (last) begin
            cnt       <= '0;
            sram_addr <= {word_idx, 1'b1};
            if (op_wr) sram_dq_out     <= wdata_hi;
            else       read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PH_HI: begin
          if (last) begin
            cnt        <= '0;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!op_wr) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized and directed checks of sram_controller against a cycle-indexed
// transaction model and a behavioural 256Kx16 SRAM.
`timescale 1ns/1ps
module tb_sram_controller;

  localparam int W    = 3;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  // Behavioural SRAM: synchronous write while we_n is low, asynchronous read.
  logic [15:0] sram_mem [0:262143];
  assign sram_dq_in = sram_mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: m_k is the cycle index within the current access
  // (-1 when idle). Access timeline: PH_LO = 1..W, PH_HI = W+1..2W, DONE = 2W+1.
  int          m_k = -1;
  bit          m_wr;
  logic [16:0] m_idx;
  logic [31:0] m_data, off;
  logic [31:0] e_rd;
  logic [17:0] e_addr;
  logic [15:0] e_dq;
  logic        e_oe;
  logic        e_we = 1'b1;
  logic [15:0] ref_half [int unsigned];

  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    return ref_half.exists(a) ? ref_half[a] : 16'h0000;
  endfunction

  always @(posedge clk) begin
    if (!e_we) ref_half[e_addr] = e_dq;
    if (rst) begin
      m_k = -1; e_rd = '0; e_addr = '0; e_dq = '0; e_oe = 1'b0; e_we = 1'b1;
    end else if (m_k < 0) begin
      if (wr_en | rd_en) begin
        off    = address - BASE;
        m_wr   = wr_en;
        m_idx  = off[18:2];
        m_data = write_data;
        m_k    = 1;
        e_addr = {m_idx, 1'b0};
        e_we   = ~m_wr;
        e_oe   = m_wr;
        if (m_wr) e_dq = m_data[15:0];
      end
    end else begin
      if (m_k == W) begin
        if (!m_wr) e_rd[15:0] = ref_rd({m_idx, 1'b0});
        e_addr = {m_idx, 1'b1};
        if (m_wr) e_dq = m_data[31:16];
      end else if (m_k == 2 * W) begin
        e_we = 1'b1;
        e_oe = 1'b0;
        if (!m_wr) e_rd[31:16] = ref_rd({m_idx, 1'b1});
      end
      m_k = (m_k == 2 * W + 1) ? -1 : m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {31'b0, ready}, (m_k < 0) ? {31'b0, ~(wr_en | rd_en)} : {31'b0, m_k == 2 * W + 1});
      check("read_data", read_data, e_rd);
      check("sram_addr", {14'b0, sram_addr}, {14'b0, e_addr});
      check("sram_we_n", {31'b0, sram_we_n}, {31'b0, e_we});
      check("sram_dq_oe", {31'b0, sram_dq_oe}, {31'b0, e_oe});
      if (e_oe) check("sram_dq_out", {16'b0, sram_dq_out}, {16'b0, e_dq});
    end
  end

  // Caller is just after a rising edge; returns just after the edge ending DONE.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        output int lows, output logic [31:0] rdv);
    bit got;
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    lows = 0; got = 1'b0; rdv = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready) begin got = 1'b1; rdv = read_data; end
      else lows++;
    end
    check("access_done", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wait_for(input string name, input bit want_ready, input logic [17:0] want_addr,
                          output int t, output logic [31:0] rdv);
    bit got = 1'b0;
    t = 0; rdv = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (want_ready ? (ready === 1'b1) : (sram_addr === want_addr)) begin
        got = 1'b1; t = cyc; rdv = read_data;
      end
    end
    check(name, {31'b0, got}, 32'd1);
  endtask

  int          lows, t0, tlo, tdummy;
  logic [31:0] rdv, rd1, rd2, prev;
  logic [17:0] saved;

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_read_data", read_data, 32'h0);
    check("rst_sram_addr", {14'b0, sram_addr}, 32'h0);
    check("rst_dq_out", {16'b0, sram_dq_out}, 32'h0);
    check("rst_oe", {31'b0, sram_dq_oe}, 32'h0);
    check("rst_we_n", {31'b0, sram_we_n}, 32'h1);
    check("rst_ready", {31'b0, ready}, 32'h1);
    @(posedge clk); #1 rst = 1'b0;

    // Write then read back one word.
    access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, lows, rdv);
    check("wr_ready_low", lows, 7);
    check("wr_sram2", {16'b0, sram_mem[2]}, 32'h0000BEEF);
    check("wr_sram3", {16'b0, sram_mem[3]}, 32'h0000DEAD);
    access(1'b0, 1'b1, 32'd1028, 32'h0, lows, rdv);
    check("rd_ready_low", lows, 7);
    check("rd_data", rdv, 32'hDEADBEEF);

    // Idle: nothing moves.
    saved = sram_addr;
    repeat (10) begin
      @(negedge clk);
      check("idle_ready", {31'b0, ready}, 32'h1);
      check("idle_we_n", {31'b0, sram_we_n}, 32'h1);
      check("idle_oe", {31'b0, sram_dq_oe}, 32'h0);
      check("idle_addr", {14'b0, sram_addr}, {14'b0, saved});
    end
    @(posedge clk); #1;

    // Both enables: write wins, read_data untouched.
    prev = read_data;
    access(1'b1, 1'b1, 32'd1024, 32'h12345678, lows, rdv);
    check("both_sram0", {16'b0, sram_mem[0]}, 32'h00005678);
    check("both_sram1", {16'b0, sram_mem[1]}, 32'h00001234);
    check("both_rd_held", rdv, prev);
    check("both_rd_held2", read_data, 32'hDEADBEEF);

    // Address change while busy: latched word 2 is used.
    access(1'b1, 1'b0, 32'd1032, 32'hA5A53C3C, lows, rdv);
    rd_en = 1'b1; address = 32'd1032;
    @(posedge clk); #1 address = 32'd2000;
    @(negedge clk);
    check("chg_addr_lo", {14'b0, sram_addr}, 32'd4);
    repeat (W) @(posedge clk);
    @(negedge clk);
    check("chg_addr_hi", {14'b0, sram_addr}, 32'd5);
    repeat (W) @(posedge clk);
    @(negedge clk);
    check("chg_ready", {31'b0, ready}, 32'h1);
    check("chg_data", read_data, 32'hA5A53C3C);
    @(posedge clk); #1 rd_en = 1'b0;

    // Reset during the second PH_HI cycle of a read.
    rd_en = 1'b1; address = 32'd1028;
    repeat (W + 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("mid_rst_rd", read_data, 32'h0);
    check("mid_rst_ready", {31'b0, ready}, {31'b0, ~(rd_en | wr_en)});
    check("mid_rst_we_n", {31'b0, sram_we_n}, 32'h1);
    @(posedge clk); #1;

    // Back-to-back loads; second request seen in the IDLE cycle after DONE.
    rd_en = 1'b1; address = 32'd1024; t0 = cyc;
    wait_for("b2b_done1", 1'b1, '0, tdummy, rd1);
    @(posedge clk); #1 address = 32'd1028;
    wait_for("b2b_lo2", 1'b0, 18'd2, tlo, rdv);
    check("b2b_lo2_cycle", tlo - t0, 2 * W + 3);
    wait_for("b2b_done2", 1'b1, '0, tdummy, rd2);
    check("b2b_rd1", rd1, 32'h12345678);
    check("b2b_rd2", rd2, 32'hDEADBEEF);
    @(posedge clk); #1 rd_en = 1'b0;

    // Random traffic, including aliasing, wrap-around and occasional resets.
    repeat (900) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 299) == 0);
      wr_en      = ($urandom_range(0, 3) == 0);
      rd_en      = ($urandom_range(0, 2) == 0);
      write_data = $urandom;
      if ($urandom_range(0, 15) == 0)
        address = $urandom;
      else
        address = BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3)
                  + (($urandom_range(0, 7) == 0) ? 32'h0008_0000 : 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (20) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
